// File: rtl/ae_sequencer.sv
// ---------------------------------------------------------------------------
// ae_sequencer
//
// Instruction sequencer for the autoencoder datapath. Fetches 16-bit
// instructions from a synchronous-read instruction memory, decodes them and
// drives the datapath control lines in a fixed multi-cycle order:
//   FETCH -> DECODE -> SELECT -> EXEC -> WRITE   (compute ops)
//   FETCH -> DECODE                              (NOP / illegal / LOOP)
//   FETCH -> DECODE -> DONE                      (HALT)
// A start/done handshake lets a host launch a program at address 0.
//
// Optional feature macro: AE_SEQ_LOOP_EN
//   defined   : opcode 0xE is a single-level hardware loop
//               (target = IR[11:4], count = IR[3:0]; body runs count+1 times)
//   undefined : opcode 0xE is illegal; no loop registers exist
//
// Ports
//   clock            in   sole clock, rising edge
//   rst_n            in   synchronous active-low reset
//   start            in   launch program at address 0 (sampled in IDLE only)
//   busy             out  high in FETCH..DONE
//   done             out  one-cycle pulse after HALT is decoded
//   illegal_op       out  sticky undefined-opcode flag, cleared by start
//   imem_addr        out  instruction address (the PC register)
//   imem_data        in   instruction word, valid one cycle after imem_addr
//   instruction      out  instruction register
//   enable_sel_mem   out  sector-select register load strobe (SELECT)
//   enable_ALU       out  ALU enable (EXEC and WRITE)
//   op_select        out  ALU op: 0 = add, 1 = multiply
//   dest_control     out  result demux: 00 mem, 01 sigmoid, 10 ReLU, 11 ReLU'
//   write_enable_mem out  data memory write strobe (WRITE)
// ---------------------------------------------------------------------------
module ae_sequencer #(
  parameter int PC_W = 8
) (
  input  logic            clock,
  input  logic            rst_n,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            illegal_op,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  output logic [15:0]     instruction,
  output logic            enable_sel_mem,
  output logic            enable_ALU,
  output logic            op_select,
  output logic [1:0]      dest_control,
  output logic            write_enable_mem
);

  localparam logic [3:0] OP_NOP       = 4'h0;
  localparam logic [3:0] OP_ADD       = 4'h1;
  localparam logic [3:0] OP_MUL       = 4'h2;
  localparam logic [3:0] OP_ADD_SIG   = 4'h3;
  localparam logic [3:0] OP_ADD_RELU  = 4'h4;
  localparam logic [3:0] OP_MUL_RELU  = 4'h5;
  localparam logic [3:0] OP_MUL_RELUD = 4'h6;
`ifdef AE_SEQ_LOOP_EN
  localparam logic [3:0] OP_LOOP      = 4'hE;
`endif
  localparam logic [3:0] OP_HALT      = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_SELECT,
    S_EXEC,
    S_WRITE,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc;
  logic [15:0]     ir_q, ir_d;
  logic            illegal_q, illegal_d;
  logic [3:0]      dec_op;
  logic            alu_phase;

`ifdef AE_SEQ_LOOP_EN
  logic            loop_active_q, loop_active_d;
  logic [3:0]      loop_cnt_q, loop_cnt_d;
  logic [PC_W-1:0] loop_target;

  // Target field is 8 bits wide; the cast truncates or zero-extends to PC_W.
  assign loop_target = PC_W'(imem_data[11:4]);
`endif

  // Wraps silently from all-ones to zero.
  assign pc_inc = pc_q + PC_W'(1);
  // Decode steers on the word arriving from memory, since IR is loaded in
  // the same cycle.
  assign dec_op = imem_data[15:12];

  // ---------------------------------------------------------------------
  // Next-state and register-update logic
  // ---------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; that is what keeps this block free of latches.
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
`ifdef AE_SEQ_LOOP_EN
    loop_active_d = loop_active_q;
    loop_cnt_d    = loop_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_FETCH;
          pc_d      = '0;
          illegal_d = 1'b0;
`ifdef AE_SEQ_LOOP_EN
          loop_active_d = 1'b0;
          loop_cnt_d    = 4'd0;
`endif
        end
      end

      S_FETCH: state_d = S_DECODE;

      S_DECODE: begin
        ir_d    = imem_data;
        state_d = S_FETCH;
        case (dec_op)
          OP_ADD, OP_MUL, OP_ADD_SIG, OP_ADD_RELU, OP_MUL_RELU, OP_MUL_RELUD:
            state_d = S_SELECT;
          OP_HALT: state_d = S_DONE;   // PC keeps the HALT address
          OP_NOP:  pc_d    = pc_inc;
`ifdef AE_SEQ_LOOP_EN
          OP_LOOP: begin
            if (!loop_active_q) begin
              // First encounter: a zero count falls straight through.
              if (imem_data[3:0] != 4'd0) begin
                loop_cnt_d    = imem_data[3:0];
                loop_active_d = 1'b1;
                pc_d          = loop_target;
              end else begin
                pc_d = pc_inc;
              end
            end else if (loop_cnt_q == 4'd1) begin
              loop_active_d = 1'b0;
              pc_d          = pc_inc;
            end else begin
              loop_cnt_d = loop_cnt_q - 4'd1;
              pc_d       = loop_target;
            end
          end
`endif
          default: begin               // undefined opcode: flag, run as NOP
            illegal_d = 1'b1;
            pc_d      = pc_inc;
          end
        endcase
      end

      S_SELECT: state_d = S_EXEC;
      S_EXEC:   state_d = S_WRITE;

      S_WRITE: begin
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // State and datapath registers (synchronous reset)
  // ---------------------------------------------------------------------
  // NOTE: registers are updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef AE_SEQ_LOOP_EN
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      loop_active_q <= 1'b0;
      loop_cnt_q    <= 4'd0;
    end else begin
      loop_active_q <= loop_active_d;
      loop_cnt_q    <= loop_cnt_d;
    end
  end
`endif

  // ---------------------------------------------------------------------
  // Outputs: decoded from the state register and IR only
  // ---------------------------------------------------------------------
  assign imem_addr        = pc_q;
  assign instruction      = ir_q;
  assign illegal_op       = illegal_q;
  assign busy             = (state_q != S_IDLE);
  assign done             = (state_q == S_DONE);
  assign enable_sel_mem   = (state_q == S_SELECT);
  assign write_enable_mem = (state_q == S_WRITE);
  assign alu_phase        = (state_q == S_EXEC) || (state_q == S_WRITE);
  assign enable_ALU       = alu_phase;

  always_comb begin
    op_select    = 1'b0;
    dest_control = 2'b00;
    if (alu_phase) begin
      case (ir_q[15:12])
        OP_ADD:       begin op_select = 1'b0; dest_control = 2'b00; end
        OP_MUL:       begin op_select = 1'b1; dest_control = 2'b00; end
        OP_ADD_SIG:   begin op_select = 1'b0; dest_control = 2'b01; end
        OP_ADD_RELU:  begin op_select = 1'b0; dest_control = 2'b10; end
        OP_MUL_RELU:  begin op_select = 1'b1; dest_control = 2'b10; end
        OP_MUL_RELUD: begin op_select = 1'b1; dest_control = 2'b11; end
        default:      begin op_select = 1'b0; dest_control = 2'b00; end
      endcase
    end
  end

endmodule
